// File: rtl/fighter_pkg.sv
// Shared action encodings, FSM states and helpers for the fighter engine.
package fighter_pkg;

  localparam int ACT_W = 6;
  localparam int CNT_W = 4;

  localparam logic [ACT_W-1:0] ACT_PUNCH      = 6'b000001;
  localparam logic [ACT_W-1:0] ACT_KICK       = 6'b000010;
  localparam logic [ACT_W-1:0] ACT_JUMP       = 6'b000100;
  localparam logic [ACT_W-1:0] ACT_WAIT       = 6'b001000;
  localparam logic [ACT_W-1:0] ACT_MOVE_LEFT  = 6'b010000;
  localparam logic [ACT_W-1:0] ACT_MOVE_RIGHT = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AIR  = 2'd1,
    ST_STUN = 2'd2,
    ST_KO   = 2'd3
  } state_t;

  function automatic logic onehot_valid(input logic [ACT_W-1:0] a);
    return (a != '0) && ((a & (a - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/fighter_player_if.sv
// Per-player bundle: own/opponent inputs and the state published to the opponent and display.
interface fighter_player_if #(
  parameter int LOC_W = 3,
  parameter int HP_W  = 3
);
  logic [5:0]       act_in;
  logic [5:0]       opp_act_in;
  logic [LOC_W-1:0] opp_loc;
  logic             opp_airborne;
  logic [LOC_W-1:0] loc_out;
  logic [HP_W-1:0]  health_out;
  logic [1:0]       state_out;
  logic             airborne_out;
  logic             hit_out;
  logic             ko_out;

  modport master (
    output act_in, opp_act_in, opp_loc, opp_airborne,
    input  loc_out, health_out, state_out, airborne_out, hit_out, ko_out
  );

  modport slave (
    input  act_in, opp_act_in, opp_loc, opp_airborne,
    output loc_out, health_out, state_out, airborne_out, hit_out, ko_out
  );
endinterface

// File: rtl/fighter_hit_resolver.sv
// Combinational resolution of the opponent's attack against own action and gap.
// FIGHTER_GUARD_EN: own WAIT in IDLE soaks one point of incoming damage.
module fighter_hit_resolver
  import fighter_pkg::*;
#(
  parameter int LOC_W       = 3,
  parameter int HP_W        = 3,
  parameter int PUNCH_RANGE = 1,
  parameter int PUNCH_DMG   = 2,
  parameter int KICK_RANGE  = 2,
  parameter int KICK_DMG    = 1
) (
  input  logic [ACT_W-1:0] own_act,
  input  logic [ACT_W-1:0] opp_act,
  input  logic [LOC_W-1:0] gap,
  input  state_t           own_state,
  input  logic             opp_airborne,
  output logic [HP_W-1:0]  dmg,
  output logic             push,
  output logic             struck
);

  logic in_punch, in_kick, exposed;

  assign in_punch = gap <= LOC_W'(PUNCH_RANGE);
  assign in_kick  = gap <= LOC_W'(KICK_RANGE);
  // AIR is immune and KO is frozen; an airborne opponent cannot attack
  assign exposed  = (own_state == ST_IDLE || own_state == ST_STUN) && !opp_airborne;

  always_comb begin
    dmg    = '0;
    push   = 1'b0;
    struck = 1'b0;
    if (exposed) begin
      if (opp_act == ACT_PUNCH && in_punch) begin
        if (own_act == ACT_PUNCH) begin
          push = 1'b1;
        end else begin
          struck = 1'b1;
          dmg    = HP_W'(PUNCH_DMG);
        end
      end else if (opp_act == ACT_KICK && in_kick) begin
        if (!(own_act == ACT_PUNCH && in_punch)) begin
          if (own_act == ACT_KICK) begin
            push = 1'b1;
          end else begin
            struck = 1'b1;
            dmg    = HP_W'(KICK_DMG);
          end
        end
      end
    end
`ifdef FIGHTER_GUARD_EN
    if (struck && own_act == ACT_WAIT && dmg != '0) begin
      dmg = dmg - 1'b1;
    end
`else
`endif
  end

endmodule

// File: rtl/fighter_player.sv
// Per-player fighter engine: location, health, healing and IDLE/AIR/STUN/KO FSM.
// Optional FIGHTER_GUARD_EN lets WAIT reduce incoming damage; all effects land one edge after sampling.
module fighter_player
  import fighter_pkg::*;
#(
  parameter int SIDE        = 1,
  parameter int ARENA_W     = 8,
  parameter int LOC_W       = 3,
  parameter int HEALTH_MAX  = 7,
  parameter int HP_W        = 3,
  parameter int START_LOC   = 5,
  parameter int HEAL_WAIT   = 2,
  parameter int JUMP_CYC    = 2,
  parameter int STUN_CYC    = 1,
  parameter int PUNCH_RANGE = 1,
  parameter int PUNCH_DMG   = 2,
  parameter int KICK_RANGE  = 2,
  parameter int KICK_DMG    = 1
) (
  input logic              clk,
  input logic              rst,
  fighter_player_if.slave  bus
);

  localparam logic [LOC_W-1:0] LOC_MAX   = LOC_W'(ARENA_W - 1);
  localparam logic [LOC_W-1:0] LOC_START = LOC_W'(START_LOC);
  localparam logic [HP_W-1:0]  HP_FULL   = HP_W'(HEALTH_MAX);
  localparam logic [CNT_W-1:0] HEAL_LAST = CNT_W'(HEAL_WAIT - 1);
  localparam logic [CNT_W-1:0] AIR_LAST  = CNT_W'(JUMP_CYC - 1);
  localparam logic [CNT_W-1:0] STUN_LAST = CNT_W'(STUN_CYC - 1);

  state_t            state_q, state_n;
  logic [LOC_W-1:0]  loc_q, loc_n;
  logic [HP_W-1:0]   health_q, health_n;
  logic [CNT_W-1:0]  heal_q, heal_n, air_q, air_n, stun_q, stun_n;
  logic              hit_q, hit_n;

  logic [LOC_W-1:0]  gap;
  logic [ACT_W-1:0]  own_eff;
  logic [HP_W-1:0]   dmg, hp_after;
  logic              push, struck;

  assign gap      = (loc_q > bus.opp_loc) ? loc_q - bus.opp_loc : bus.opp_loc - loc_q;
  // Own actions only count in IDLE; anything not one-hot degrades to a no-op
  assign own_eff  = (state_q == ST_IDLE && onehot_valid(bus.act_in)) ? bus.act_in : '0;
  assign hp_after = (health_q > dmg) ? health_q - dmg : '0;

  fighter_hit_resolver #(
    .LOC_W(LOC_W), .HP_W(HP_W),
    .PUNCH_RANGE(PUNCH_RANGE), .PUNCH_DMG(PUNCH_DMG),
    .KICK_RANGE(KICK_RANGE), .KICK_DMG(KICK_DMG)
  ) u_resolver (
    .own_act(own_eff), .opp_act(bus.opp_act_in), .gap(gap), .own_state(state_q),
    .opp_airborne(bus.opp_airborne), .dmg(dmg), .push(push), .struck(struck)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      loc_q    <= LOC_START;
      health_q <= HP_FULL;
      heal_q   <= '0;
      air_q    <= '0;
      stun_q   <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      loc_q    <= loc_n;
      health_q <= health_n;
      heal_q   <= heal_n;
      air_q    <= air_n;
      stun_q   <= stun_n;
      hit_q    <= hit_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    loc_n    = loc_q;
    health_n = health_q;
    heal_n   = heal_q;
    air_n    = air_q;
    stun_n   = stun_q;
    hit_n    = 1'b0;
    if (state_q != ST_KO) begin
      if (struck) heal_n = '0;
      if (dmg != '0) begin
        // A landed hit beats any simultaneous own action, including JUMP
        health_n = hp_after;
        hit_n    = 1'b1;
        heal_n   = '0;
        stun_n   = '0;
        state_n  = (hp_after == '0) ? ST_KO : ST_STUN;
      end else if (push) begin
        heal_n = '0;
        if (SIDE == 1) begin
          if (loc_q != LOC_MAX) loc_n = loc_q + 1'b1;
        end else begin
          if (loc_q != '0) loc_n = loc_q - 1'b1;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (own_eff != ACT_WAIT) heal_n = '0;
            unique case (own_eff)
              ACT_MOVE_RIGHT:
                if (loc_q != LOC_MAX && loc_q + 1'b1 != bus.opp_loc) loc_n = loc_q + 1'b1;
              ACT_MOVE_LEFT:
                if (loc_q != '0 && loc_q - 1'b1 != bus.opp_loc) loc_n = loc_q - 1'b1;
              ACT_JUMP: begin
                state_n = ST_AIR;
                air_n   = '0;
              end
              ACT_WAIT:
                if (!struck) begin
                  if (heal_q == HEAL_LAST) begin
                    heal_n = '0;
                    if (health_q != HP_FULL) health_n = health_q + 1'b1;
                  end else begin
                    heal_n = heal_q + 1'b1;
                  end
                end
              default: ;
            endcase
          end
          ST_AIR: begin
            if (air_q == AIR_LAST) begin
              state_n = ST_IDLE;
              air_n   = '0;
            end else begin
              air_n = air_q + 1'b1;
            end
          end
          ST_STUN: begin
            if (stun_q == STUN_LAST) begin
              state_n = ST_IDLE;
              stun_n  = '0;
            end else begin
              stun_n = stun_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.loc_out      = loc_q;
  assign bus.health_out   = health_q;
  assign bus.state_out    = state_q;
  assign bus.airborne_out = (state_q == ST_AIR);
  assign bus.hit_out      = hit_q;
  assign bus.ko_out       = (state_q == ST_KO);

endmodule

// File: tb/tb_fighter_player.sv
// Directed bench for fighter_player (SIDE=1, START_LOC=5), guard feature disabled.
module tb_fighter_player;

  localparam logic [5:0] P  = 6'b000001;
  localparam logic [5:0] K  = 6'b000010;
  localparam logic [5:0] J  = 6'b000100;
  localparam logic [5:0] W  = 6'b001000;
  localparam logic [5:0] ML = 6'b010000;
  localparam logic [5:0] MR = 6'b100000;
  localparam logic [5:0] NO = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fighter_player_if #(.LOC_W(3), .HP_W(3)) bus ();

  fighter_player dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] own, input logic [5:0] opp, input logic [2:0] oloc);
    bus.act_in     = own;
    bus.opp_act_in = opp;
    bus.opp_loc    = oloc;
  endtask

  task automatic do_reset();
    drive(NO, NO, 3'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic expect_st(input string tag, input int loc, input int hp, input int st, input int hit);
    check({tag, "_loc"}, int'(bus.loc_out), loc);
    check({tag, "_hp"}, int'(bus.health_out), hp);
    check({tag, "_st"}, int'(bus.state_out), st);
    check({tag, "_hit"}, int'(bus.hit_out), hit);
  endtask

  initial begin
    bus.opp_airborne = 1'b0;
    do_reset();
    expect_st("reset", 5, 7, 0, 0);
    check("reset_ko", int'(bus.ko_out), 0);
    check("reset_air", int'(bus.airborne_out), 0);

    // punch at gap 1: 2 damage, one-cycle stun
    drive(NO, P, 3'd4); step();
    expect_st("punch", 5, 5, 2, 1);
    drive(NO, NO, 3'd4); step();
    expect_st("punch_rec", 5, 5, 0, 0);

    // reset mid-jump restores everything
    drive(J, NO, 3'd4); step();
    check("jump_air", int'(bus.airborne_out), 1);
    drive(NO, NO, 3'd4); step();
    check("jump_air2", int'(bus.state_out), 1);
    rst = 1'b1; step(); rst = 1'b0;
    expect_st("rst_air", 5, 7, 0, 0);
    check("rst_air_ko", int'(bus.ko_out), 0);

    // mutual punches push right, blocked at the wall
    drive(P, P, 3'd4); step();
    expect_st("push1", 6, 7, 0, 0);
    drive(P, P, 3'd5); step();
    expect_st("push2", 7, 7, 0, 0);
    drive(P, P, 3'd6); step();
    expect_st("push_wall", 7, 7, 0, 0);

    // airborne for exactly two cycles, immune to a kick meanwhile
    do_reset();
    drive(J, NO, 3'd4); step();
    check("air_c1", int'(bus.airborne_out), 1);
    drive(NO, K, 3'd4); step();
    check("air_c2", int'(bus.airborne_out), 1);
    check("air_hp", int'(bus.health_out), 7);
    drive(NO, NO, 3'd4); step();
    check("air_end", int'(bus.airborne_out), 0);
    expect_st("air_land", 5, 7, 0, 0);

    // opponent airborne: its punch is ignored
    bus.opp_airborne = 1'b1;
    drive(NO, P, 3'd4); step();
    check("opp_air_hp", int'(bus.health_out), 7);
    bus.opp_airborne = 1'b0;

    // hits during stun keep landing; kick at gap 2 finishes to KO
    drive(NO, P, 3'd4); step();
    check("ko_h5", int'(bus.health_out), 5);
    step();
    check("ko_h3", int'(bus.health_out), 3);
    step();
    expect_st("ko_h1", 5, 1, 2, 1);
    drive(NO, K, 3'd3); step();
    expect_st("ko_hit", 5, 0, 3, 1);
    check("ko_flag", int'(bus.ko_out), 1);
    drive(W, NO, 3'd3); step(); step(); step();
    check("ko_wait_hp", int'(bus.health_out), 0);
    drive(ML, NO, 3'd1); step();
    check("ko_move_loc", int'(bus.loc_out), 5);
    check("ko_sticky", int'(bus.ko_out), 1);

    // heal: +1 every two consecutive WAITs, saturating
    do_reset();
    drive(NO, P, 3'd4); step();
    drive(NO, NO, 3'd4); step();
    check("heal_start", int'(bus.health_out), 5);
    drive(W, NO, 3'd4);
    step(); check("heal_w1", int'(bus.health_out), 5);
    step(); check("heal_w2", int'(bus.health_out), 6);
    step(); check("heal_w3", int'(bus.health_out), 6);
    step(); check("heal_w4", int'(bus.health_out), 7);
    step(); step(); check("heal_sat", int'(bus.health_out), 7);

    // movement rules
    drive(ML, NO, 3'd4); step();
    check("move_blocked", int'(bus.loc_out), 5);
    drive(ML | MR, NO, 3'd4); step();
    check("move_multi", int'(bus.loc_out), 5);
    drive(MR, NO, 3'd4); step();
    check("move_right", int'(bus.loc_out), 6);

    // gap 2: punch misses; own punch does not cover a kick out of punch range
    drive(NO, P, 3'd4); step();
    check("punch_gap2", int'(bus.health_out), 7);
    drive(P, K, 3'd4); step();
    expect_st("kick_gap2", 6, 6, 2, 1);
    drive(NO, NO, 3'd4); step();
    // own punch in range cancels a kick; gap 3 is out of kick range
    drive(P, K, 3'd5); step();
    expect_st("kick_parry", 6, 6, 0, 0);
    drive(NO, K, 3'd3); step();
    check("kick_gap3", int'(bus.health_out), 6);
    drive(K, K, 3'd5); step();
    check("kick_push", int'(bus.loc_out), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
